parallel_fir_sequencer: RTL and testbench

Control sequencer for the parallel DSP58 FIR datapath. It loads the coefficient bank, gates sample entry into the tap delay line, and tracks when the tap window is full. It also generates the output-valid strobe aligned to the DSP pipeline latency, and flushes the filter tail with injected zeros. It sits between the upstream sample source / coefficient source and the FIR delay-unit + DSP58 chain.

---
 rtl/parallel_fir_sequencer.sv | 178 +++++++++++++++++
 tb/tb_parallel_fir_sequencer.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/parallel_fir_sequencer.sv
// parallel_fir_sequencer
// Control sequencer for the parallel DSP58 FIR datapath. It loads the
// coefficient bank, admits samples into the tap delay line, flushes the
// filter tail with zero slots, and produces m_valid aligned to the DSP
// pipeline latency.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high. Valid does not depend on ready. Ready is driven only from
// registered state, so it never depends combinationally on valid.
// Coefficient channel: coef_valid / coef_ready, and coef_wr_en marks the
// transfer. Sample channel: s_valid / s_ready, and the transfer is the
// tap_shift_en cycle with zero_insert low.
module parallel_fir_sequencer #(
  parameter int FILTER_LENGTH = 16,
  parameter int DSP_LATENCY   = 4,
  parameter int ADDR_W        = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              reload,
  input  logic              coef_valid,
  output logic              coef_ready,
  output logic              coef_wr_en,
  output logic [ADDR_W-1:0] coef_addr,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic              flush,
  output logic              tap_shift_en,
  output logic              zero_insert,
  output logic              m_valid,
  output logic              coef_loaded,
  output logic              busy,
  output logic [2:0]        dbg_state
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_RUN   = 3'd2,
    ST_FLUSH = 3'd3,
    ST_DRAIN = 3'd4
  } state_t;

  localparam int SLOT_W  = $clog2(FILTER_LENGTH + 1);
  localparam int MAX_CNT = (FILTER_LENGTH > DSP_LATENCY) ? FILTER_LENGTH : DSP_LATENCY;
  localparam int CNT_W   = $clog2(MAX_CNT + 1);

  localparam logic [ADDR_W-1:0] ADDR_LAST  = ADDR_W'(FILTER_LENGTH - 1);
  localparam logic [SLOT_W-1:0] SLOT_MAX   = SLOT_W'(FILTER_LENGTH);
  localparam logic [SLOT_W-1:0] SLOT_FULL  = SLOT_W'(FILTER_LENGTH - 1);
  localparam logic [CNT_W-1:0]  FLUSH_LAST = CNT_W'((FILTER_LENGTH > 1) ? (FILTER_LENGTH - 2) : 0);
  localparam logic [CNT_W-1:0]  DRAIN_LAST = CNT_W'(DSP_LATENCY - 1);

  state_t                  state;
  state_t                  next_state;
  logic [CNT_W-1:0]        phase_cnt;
  logic [SLOT_W-1:0]       slot_cnt;
  logic                    s_ready_q;
  logic                    accept;
  logic                    full_slot;
  logic [DSP_LATENCY-1:0]  valid_dly;

  assign s_ready   = s_ready_q;
  assign dbg_state = state;
  assign m_valid   = valid_dly[DSP_LATENCY-1];

  // Next-state decode and the combinational strobes derived from state.
  always_comb begin
    next_state   = state;
    coef_ready   = 1'b0;
    coef_wr_en   = 1'b0;
    accept       = 1'b0;
    tap_shift_en = 1'b0;
    zero_insert  = 1'b0;
    busy         = (state != ST_IDLE);
    unique case (state)
      ST_IDLE: begin
        if (start) begin
          if (reload || !coef_loaded) next_state = ST_LOAD;
          else                        next_state = ST_RUN;
        end
      end
      ST_LOAD: begin
        coef_ready = 1'b1;
        coef_wr_en = coef_valid;
        if (coef_valid && (coef_addr == ADDR_LAST)) next_state = ST_RUN;
      end
      ST_RUN: begin
        accept       = s_valid && s_ready_q;
        tap_shift_en = accept;
        // A one-tap filter has no tail to flush.
        if (flush) next_state = (FILTER_LENGTH > 1) ? ST_FLUSH : ST_DRAIN;
      end
      ST_FLUSH: begin
        tap_shift_en = 1'b1;
        zero_insert  = 1'b1;
        if (phase_cnt == FLUSH_LAST) next_state = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (phase_cnt == DRAIN_LAST) next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // A slot completes the tap window once FILTER_LENGTH slots including it
  // have entered the delay line.
  assign full_slot = tap_shift_en && (slot_cnt >= SLOT_FULL);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= next_state;
  end

  // Cycle counter for the fixed-length FLUSH and DRAIN phases; restarts on every state change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_cnt <= '0;
    end else if (state != next_state) begin
      phase_cnt <= '0;
    end else if ((state == ST_FLUSH) || (state == ST_DRAIN)) begin
      phase_cnt <= phase_cnt + 1'b1;
    end
  end

  // Coefficient bank address and the "complete set present" flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      coef_addr   <= '0;
      coef_loaded <= 1'b0;
    end else if ((state == ST_IDLE) && (next_state == ST_LOAD)) begin
      coef_addr   <= '0;
      coef_loaded <= 1'b0;
    end else if (coef_wr_en) begin
      if (coef_addr == ADDR_LAST) begin
        coef_addr   <= '0;
        coef_loaded <= 1'b1;
      end else begin
        coef_addr <= coef_addr + 1'b1;
      end
    end
  end

  // s_ready is a flop so it is high for every cycle spent in RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) s_ready_q <= 1'b0;
    else        s_ready_q <= (next_state == ST_RUN);
  end

  // Saturating count of slots shifted in this pass; cleared when DRAIN returns to IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_cnt <= '0;
    end else if ((state == ST_DRAIN) && (next_state == ST_IDLE)) begin
      slot_cnt <= '0;
    end else if (tap_shift_en && (slot_cnt != SLOT_MAX)) begin
      slot_cnt <= slot_cnt + 1'b1;
    end
  end

  // Valid delay line matching the DSP chain latency; it advances in every state.
  generate
    if (DSP_LATENCY > 1) begin : g_dly_multi
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) valid_dly <= '0;
        else        valid_dly <= {valid_dly[DSP_LATENCY-2:0], full_slot};
      end
    end else begin : g_dly_single
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) valid_dly <= '0;
        else        valid_dly <= full_slot;
      end
    end
  endgenerate

endmodule

// File: tb/tb_parallel_fir_sequencer.sv
// tb_parallel_fir_sequencer
// Self-checking bench for parallel_fir_sequencer: per-cycle vector records
// for control outputs and a scoreboard of expected m_valid cycle numbers.
module tb_parallel_fir_sequencer;

  localparam int FL     = 16;
  localparam int DL     = 4;
  localparam int ADDR_W = 4;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic              start, reload, coef_valid, s_valid, flush;
  logic              coef_ready, coef_wr_en, s_ready, tap_shift_en, zero_insert;
  logic              m_valid, coef_loaded, busy;
  logic [ADDR_W-1:0] coef_addr;
  logic [2:0]        dbg_state;

  parallel_fir_sequencer #(
    .FILTER_LENGTH(FL),
    .DSP_LATENCY  (DL),
    .ADDR_W       (ADDR_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .reload      (reload),
    .coef_valid  (coef_valid),
    .coef_ready  (coef_ready),
    .coef_wr_en  (coef_wr_en),
    .coef_addr   (coef_addr),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .flush       (flush),
    .tap_shift_en(tap_shift_en),
    .zero_insert (zero_insert),
    .m_valid     (m_valid),
    .coef_loaded (coef_loaded),
    .busy        (busy),
    .dbg_state   (dbg_state)
  );

  typedef struct {
    logic start, reload, s_valid, flush, coef_valid;
    logic e_busy, e_s_ready, e_shift, e_zero, e_coef_ready;
  } vec_t;

  logic [31:0] exp_q[$];
  logic [31:0] cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  int          mv_count = 0;
  int          slots = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic st, rl, sv, fl, cv, eb, esr, esh, ez, ecr);
    vec_t v;
    v.start = st; v.reload = rl; v.s_valid = sv; v.flush = fl; v.coef_valid = cv;
    v.e_busy = eb; v.e_s_ready = esr; v.e_shift = esh; v.e_zero = ez; v.e_coef_ready = ecr;
    return v;
  endfunction

  // Bench-side slot model: a shifted slot that completes the window produces
  // m_valid exactly DL cycles later.
  task automatic note_shift();
    if (slots + 1 >= FL) exp_q.push_back(cyc + DL);
    if (slots < FL) slots++;
  endtask

  // Drive one cycle of inputs, check control outputs, advance one clock.
  task automatic apply(input vec_t v, input string tag);
    start = v.start; reload = v.reload; s_valid = v.s_valid;
    flush = v.flush; coef_valid = v.coef_valid;
    #2;
    check({tag, ".busy"},       busy,         v.e_busy);
    check({tag, ".s_ready"},    s_ready,      v.e_s_ready);
    check({tag, ".shift"},      tap_shift_en, v.e_shift);
    check({tag, ".zero"},       zero_insert,  v.e_zero);
    check({tag, ".coef_ready"}, coef_ready,   v.e_coef_ready);
    check({tag, ".coef_wr_en"}, coef_wr_en,   v.e_coef_ready & v.coef_valid);
    if (v.e_shift) note_shift();
    tick();
  endtask

  // Scoreboard: pop expected m_valid cycles as the DUT produces them.
  always @(negedge clk) begin
    if (rst_n) begin
      if (exp_q.size() > 0 && exp_q[0] < cyc) begin
        n_checks++; n_fail++;
        $display("FAIL m_valid_missing: got 0 expected 1 (cycle %0d)", exp_q[0]);
        void'(exp_q.pop_front());
      end
      if (m_valid) begin
        logic [31:0] e;
        n_checks++;
        mv_count++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL m_valid_unexpected: got 1 expected 0 (cycle %0d)", cyc);
        end else begin
          e = exp_q.pop_front();
          if (e != cyc) begin
            n_fail++;
            $display("FAIL m_valid_timing: got cycle %0d expected cycle %0d", cyc, e);
          end
        end
      end
    end
  end

  // Driver for a coefficient load starting in the first LOAD cycle; coef_valid
  // drops every third cycle. abort_at >= 0 pulses rst_n at that write.
  task automatic load_coefs(input int abort_at);
    int nwr;
    nwr = 0;
    for (int i = 0; i < 100 && nwr < FL; i++) begin
      coef_valid = (i % 3 != 2);
      #2;
      check("load.coef_ready",  coef_ready,  1);
      check("load.coef_loaded", coef_loaded, 0);
      check("load.coef_wr_en",  coef_wr_en,  coef_valid);
      if (coef_valid) begin
        check("load.coef_addr", coef_addr, nwr);
        if (nwr == abort_at) begin
          rst_n = 1'b0;
          #1;
          check("abort.busy",        busy,        0);
          check("abort.coef_loaded", coef_loaded, 0);
          check("abort.coef_addr",   coef_addr,   0);
          check("abort.coef_ready",  coef_ready,  0);
          check("abort.coef_wr_en",  coef_wr_en,  0);
          coef_valid = 1'b0;
          @(posedge clk);
          #1;
          rst_n = 1'b1;
          slots = 0;
          return;
        end
        nwr++;
      end
      tick();
    end
    coef_valid = 1'b0;
    check("load.write_count", nwr, FL);
  endtask

  // FLUSH (FL-1 zero slots) then DRAIN (DL cycles) then one IDLE cycle.
  task automatic flush_tail(input string tag);
    for (int i = 0; i < FL - 1; i++) apply(mk(0,0,0,0,0, 1,0,1,1,0), {tag, ".flush"});
    for (int i = 0; i < DL; i++)     apply(mk(0,0,0,0,0, 1,0,0,0,0), {tag, ".drain"});
    slots = 0;
    apply(mk(0,0,0,0,0, 0,0,0,0,0), {tag, ".idle"});
  endtask

  initial begin
    vec_t vecs[$];

    // Restart without reload, short burst with a gap, sample+flush in one
    // cycle, then start/coef_valid/flush held during DRAIN.
    vecs.push_back(mk(1,0,0,0,1, 0,0,0,0,0));
    vecs.push_back(mk(0,0,1,0,1, 1,1,1,0,0));
    vecs.push_back(mk(0,0,1,0,1, 1,1,1,0,0));
    vecs.push_back(mk(0,0,0,0,0, 1,1,0,0,0));
    vecs.push_back(mk(0,0,1,1,0, 1,1,1,0,0));
    for (int i = 0; i < FL - 1; i++) vecs.push_back(mk(0,0,1,0,0, 1,0,1,1,0));
    for (int i = 0; i < DL; i++)     vecs.push_back(mk(1,0,0,1,1, 1,0,0,0,0));
    vecs.push_back(mk(0,0,0,0,0, 0,0,0,0,0));
    vecs.push_back(mk(0,0,0,0,0, 0,0,0,0,0));

    start = 0; reload = 0; coef_valid = 0; s_valid = 0; flush = 0;

    // reset state
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    check("rst.busy",        busy,         0);
    check("rst.coef_ready",  coef_ready,   0);
    check("rst.coef_wr_en",  coef_wr_en,   0);
    check("rst.coef_addr",   coef_addr,    0);
    check("rst.coef_loaded", coef_loaded,  0);
    check("rst.s_ready",     s_ready,      0);
    check("rst.shift",       tap_shift_en, 0);
    check("rst.zero",        zero_insert,  0);
    check("rst.m_valid",     m_valid,      0);
    tick();
    rst_n = 1'b1;
    tick();

    // load aborted by reset at write 7
    apply(mk(1,0,0,0,0, 0,0,0,0,0), "idle_start1");
    start = 0;
    load_coefs(7);
    #2;
    check("post_abort.busy",        busy,        0);
    check("post_abort.coef_loaded", coef_loaded, 0);
    tick();

    // full load (coef_loaded=0, reload=0 still loads)
    apply(mk(1,0,0,0,0, 0,0,0,0,0), "idle_start2");
    start = 0;
    load_coefs(-1);
    #2;
    check("run_entry.coef_loaded", coef_loaded, 1);
    check("run_entry.coef_addr",   coef_addr,   0);
    check("run_entry.s_ready",     s_ready,     1);
    check("run_entry.busy",        busy,        1);

    // streaming: 20 back-to-back samples, then flush tail
    for (int i = 0; i < 20; i++) apply(mk(0,0,1,0,0, 1,1,1,0,0), "stream");
    apply(mk(0,0,0,1,0, 1,1,0,0,0), "stream.flush_req");
    flush_tail("stream");
    check("stream.m_valid_total", mv_count, 20);

    // table-driven vectors
    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], $sformatf("vec[%0d]", i));
    slots = 0;
    check("table.m_valid_total", mv_count, 23);
    check("table.coef_loaded", coef_loaded, 1);

    // restart with reload: LOAD, coef_loaded drops, then flush with no samples
    apply(mk(1,1,0,0,0, 0,0,0,0,0), "idle_reload");
    start = 0; reload = 0;
    load_coefs(-1);
    apply(mk(0,0,0,1,0, 1,1,0,0,0), "reload.flush_req");
    flush_tail("reload");

    repeat (DL + 2) tick();
    check("final.scoreboard_empty", exp_q.size(), 0);
    check("final.m_valid_total",    mv_count,     23);
    check("final.busy",             busy,         0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
